// File: rtl/pony_pkg.sv
`default_nettype none
// ============================================================================
// Module : pony_pkg
// Shared sizes, register map, reset defaults and FSM encoding.
// Rev    : 1.0
// ============================================================================
package pony_pkg;

    localparam int NUM_REGISTERS_DEF = 7;
    localparam int LEN_REGISTER_DEF  = 8;
    localparam int ADDR_W            = 3;

    localparam int IDX_COLOR1   = 0;
    localparam int IDX_COLOR2   = 1;
    localparam int IDX_COLOR3   = 2;
    localparam int IDX_COLOR4   = 3;
    localparam int IDX_SPRITE_X = 4;
    localparam int IDX_SPRITE_Y = 5;
    localparam int IDX_MISC     = 6;

    localparam logic [7:0] RST_COLOR1   = 8'h3F;
    localparam logic [7:0] RST_COLOR2   = 8'h00;
    localparam logic [7:0] RST_COLOR3   = 8'h2A;
    localparam logic [7:0] RST_COLOR4   = 8'h15;
    localparam logic [7:0] RST_SPRITE_X = 8'd64;
    localparam logic [7:0] RST_SPRITE_Y = 8'd64;
    localparam logic [7:0] RST_MISC     = 8'h00;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_COMMIT = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

    // Entries beyond the defined register map come up as zero.
    function automatic logic [7:0] reset_value(input int idx);
        case (idx)
            IDX_COLOR1:   return RST_COLOR1;
            IDX_COLOR2:   return RST_COLOR2;
            IDX_COLOR3:   return RST_COLOR3;
            IDX_COLOR4:   return RST_COLOR4;
            IDX_SPRITE_X: return RST_SPRITE_X;
            IDX_SPRITE_Y: return RST_SPRITE_Y;
            IDX_MISC:     return RST_MISC;
            default:      return 8'h00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter2
// Two-requester round-robin arbiter; requester 0 wins the first tie.
// Rev    : 1.0
// ============================================================================
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last0_d, last0_q;  // set when requester 0 held the most recent grant

    always_comb begin
        gnt_o   = 2'b00;
        last0_d = last0_q;
        if (en_i) begin
            if (req_i == 2'b11) begin
                gnt_o = last0_q ? 2'b10 : 2'b01;
            end else begin
                gnt_o = req_i;
            end
        end
        if (gnt_o[0]) begin
            last0_d = 1'b1;
        end else if (gnt_o[1]) begin
            last0_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last0_q <= 1'b0;
        end else begin
            last0_q <= last0_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module : reg_commit_ctrl
// Display register bank fed by SPI and animator; REG_COMMIT_SHADOW_EN adds
// a shadow bank committed to the active bank at frame start.
// Rev    : 1.0
// ============================================================================
module reg_commit_ctrl
    import pony_pkg::*;
#(
    parameter int NUM_REGISTERS = NUM_REGISTERS_DEF,
    parameter int LEN_REGISTER  = LEN_REGISTER_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    spi_valid,
    input  logic [ADDR_W-1:0]       spi_addr,
    input  logic [LEN_REGISTER-1:0] spi_data,
    output logic                    spi_ready,
    input  logic                    anim_valid,
    input  logic [ADDR_W-1:0]       anim_addr,
    input  logic [LEN_REGISTER-1:0] anim_data,
    output logic                    anim_ready,
    input  logic                    frame_start,
    output logic [5:0]              color1,
    output logic [5:0]              color2,
    output logic [5:0]              color3,
    output logic [5:0]              color4,
    output logic [7:0]              sprite_x,
    output logic [7:0]              sprite_y,
    output logic [4:0]              misc,
    output logic                    busy,
    output logic                    addr_err
);

    logic [1:0]              gnt;
    logic                    accept_en;
    logic                    wr_en;
    logic                    wr_ok;
    logic [ADDR_W-1:0]       wr_addr;
    logic [LEN_REGISTER-1:0] wr_data;
    logic                    addr_err_d, addr_err_q;
    logic [LEN_REGISTER-1:0] active_d [NUM_REGISTERS];
    logic [LEN_REGISTER-1:0] active_q [NUM_REGISTERS];

    rr_arbiter2 u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (accept_en),
        .req_i  ({anim_valid, spi_valid}),
        .gnt_o  (gnt)
    );

    assign spi_ready  = gnt[0];
    assign anim_ready = gnt[1];
    assign wr_en      = |gnt;
    assign wr_addr    = gnt[1] ? anim_addr : spi_addr;
    assign wr_data    = gnt[1] ? anim_data : spi_data;
    assign wr_ok      = (int'(wr_addr) < NUM_REGISTERS);
    assign addr_err_d = addr_err_q | (wr_en & ~wr_ok);

`ifdef REG_COMMIT_SHADOW_EN
    state_t                  state_d, state_q;
    logic [ADDR_W-1:0]       idx_d, idx_q;
    logic [NUM_REGISTERS-1:0] dirty_d, dirty_q;
    logic [LEN_REGISTER-1:0] shadow_d [NUM_REGISTERS];
    logic [LEN_REGISTER-1:0] shadow_q [NUM_REGISTERS];

    assign accept_en = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dirty_d  = dirty_q;
        shadow_d = shadow_q;
        active_d = active_q;
        case (state_q)
            ST_IDLE: begin
                // The write accepted alongside frame_start lands before the scan reads it.
                if (wr_en && wr_ok) begin
                    shadow_d[wr_addr] = wr_data;
                    dirty_d[wr_addr]  = 1'b1;
                end
                if (frame_start) begin
                    state_d = ST_COMMIT;
                    idx_d   = '0;
                end
            end
            ST_COMMIT: begin
                if (dirty_q[idx_q]) begin
                    active_d[idx_q] = shadow_q[idx_q];
                    dirty_d[idx_q]  = 1'b0;
                end
                if (int'(idx_q) == NUM_REGISTERS - 1) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            dirty_q <= '0;
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                shadow_q[i] <= LEN_REGISTER'(reset_value(i));
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dirty_q  <= dirty_d;
            shadow_q <= shadow_d;
        end
    end
`else
    logic unused_frame_start;

    assign accept_en          = 1'b1;
    assign busy               = 1'b0;
    assign unused_frame_start = frame_start;

    always_comb begin
        active_d = active_q;
        if (wr_en && wr_ok) begin
            active_d[wr_addr] = wr_data;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_err_q <= 1'b0;
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                active_q[i] <= LEN_REGISTER'(reset_value(i));
            end
        end else begin
            addr_err_q <= addr_err_d;
            active_q   <= active_d;
        end
    end

    assign color1   = active_q[IDX_COLOR1][5:0];
    assign color2   = active_q[IDX_COLOR2][5:0];
    assign color3   = active_q[IDX_COLOR3][5:0];
    assign color4   = active_q[IDX_COLOR4][5:0];
    assign sprite_x = active_q[IDX_SPRITE_X][7:0];
    assign sprite_y = active_q[IDX_SPRITE_Y][7:0];
    assign misc     = active_q[IDX_MISC][4:0];
    assign addr_err = addr_err_q;

    logic unused_bits;
    assign unused_bits = ^{active_q[IDX_COLOR1][LEN_REGISTER-1:6],
                           active_q[IDX_COLOR2][LEN_REGISTER-1:6],
                           active_q[IDX_COLOR3][LEN_REGISTER-1:6],
                           active_q[IDX_COLOR4][LEN_REGISTER-1:6],
                           active_q[IDX_MISC][LEN_REGISTER-1:5]};

endmodule
`default_nettype wire

// File: doc/reg_commit_ctrl.md
REG_COMMIT_CTRL -- requirements
Module: reg_commit_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGISTERS, default 7, the number of sprite/colour registers.
REQ-002 SHALL have parameter LEN_REGISTER, default 8, the register width in bits.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk_i  input  1  clock, all state on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active low.
REQ-006 spi_valid / spi_addr / spi_data  input  1/3/8  write request from SPI receiver.
REQ-007 spi_ready  output  1  SPI write accepted this cycle.
REQ-008 anim_valid / anim_addr / anim_data  input  1/3/8  write request from sprite animator.
REQ-009 anim_ready  output  1  animator write accepted this cycle.
REQ-010 frame_start  input  1  one-cycle pulse at vertical blank start.
REQ-011 color1..color4  output  6 each  active colour registers 0..3, low bits.
REQ-012 sprite_x, sprite_y  output  8 each  active registers 4, 5.
REQ-013 misc  output  5  active register 6, low bits.
REQ-014 busy  output  1  high while COMMIT runs.
REQ-015 addr_err  output  1  sticky, set by any accepted write with addr >= NUM_REGISTERS.

Function
REQ-016 SHALL hold a shadow array and an active array, each NUM_REGISTERS x LEN_REGISTER, plus one dirty bit per shadow entry.
REQ-017 SHALL arbitrate the two write ports round-robin: on simultaneous valid, grant the port not granted last; after reset SPI has priority.
REQ-018 SHALL accept at most one write per cycle; ready is combinational, high only for the granted port and only in state IDLE.
REQ-019 Accepted write with valid address SHALL update shadow[addr] and set dirty[addr] at the next edge; invalid address SHALL change no register and set addr_err.
REQ-020 FSM states SHALL be IDLE, COMMIT, DONE.
REQ-021 IDLE -> COMMIT on frame_start; the frame_start cycle SHALL still accept a write, which is included in the commit.
REQ-022 COMMIT SHALL scan index 0..NUM_REGISTERS-1, one index per cycle; if dirty, copy shadow to active and clear dirty.
REQ-023 COMMIT -> DONE after the last index; DONE -> IDLE after one cycle; total busy = NUM_REGISTERS+1 cycles.
REQ-024 Write ports SHALL be stalled (ready low) during COMMIT and DONE; requests hold until accepted.
REQ-025 frame_start during COMMIT or DONE SHALL be ignored and not queued.
REQ-026 Outputs SHALL be combinational slices of the active array only; shadow writes never visible before commit.

Reset
REQ-027 Reset SHALL force IDLE, clear dirty bits, addr_err and last-grant, and load both arrays with package defaults.
REQ-028 Reset mid-COMMIT SHALL abandon the scan; no partial-commit values persist.
REQ-029 Reset values: color1 6'h3F, color2 6'h00, color3 6'h2A, color4 6'h15, sprite_x 8'd64, sprite_y 8'd64, misc 5'b00000; busy 0; ready 0.

Configuration
REQ-030 Macro REG_COMMIT_SHADOW_EN defined: shadow/commit behaviour as REQ-016..REQ-028.
REQ-031 Macro undefined: no shadow array or FSM; accepted writes update active directly next edge, frame_start ignored, busy tied 0, ready never stalled.

Structure
REQ-032 Package pony_pkg SHALL hold NUM_REGISTERS/LEN_REGISTER defaults, register index constants, reset-default constants, and the FSM state typedef.
REQ-033 Sub-module rr_arbiter2 SHALL implement the two-requester round-robin grant with last-grant state.

Verification
REQ-034 SPI write addr 4 data 8'h20, no frame_start -> sprite_x stays 64; frame_start -> sprite_x 8'h20 within 8 cycles, busy high exactly 8 cycles.
REQ-035 Both ports valid every cycle for 4 cycles, addrs 0 and 1 -> grants alternate SPI, anim, SPI, anim.
REQ-036 SPI write held valid across frame_start+1..+8 -> spi_ready low throughout, accepted first IDLE cycle, committed next frame only.
REQ-037 Write addr 7 data 8'hFF -> addr_err 1, all outputs unchanged after commit.
REQ-038 rst_ni low at COMMIT index 3 -> all outputs return to reset values asynchronously, state IDLE, dirty clear.
REQ-039 Macro undefined: write addr 0 data 6'h01 -> color1 6'h01 next cycle, no frame_start needed.
